imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-002 The block SHALL provide port start, input, width 1: a one-cycle pulse that begins a load session.
REQ-003 The block SHALL provide port byte_valid, input, width 1: the host presents a byte.
REQ-004 The block SHALL provide port byte_data, input, width 8: the host byte.
REQ-005 The block SHALL provide port byte_ready, output, width 1: the loader accepts a byte this cycle.
REQ-006 The block SHALL provide port mem_we, output, width 1: a one-cycle instruction-memory write strobe.
REQ-007 The block SHALL provide port mem_addr, output, width 12: the instruction word index.
REQ-008 The block SHALL provide port mem_wdata, output, width 32: the instruction word.
REQ-009 The block SHALL provide port cpu_hold, output, width 1: holds the CPU program counter in reset while high.
REQ-010 The block SHALL provide ports done and err, outputs, width 1 each: session status.

Function
REQ-011 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both high; bytes offered in other cycles SHALL be ignored.
REQ-012 Stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words of 4 bytes each (little-endian, first byte = bits 7:0), then 1 checksum byte.
REQ-013 The FSM SHALL have states IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
REQ-014 byte_ready SHALL be high exactly in LEN_LO, LEN_HI, DATA, and CHECK.
REQ-015 start SHALL move the FSM from IDLE, DONE, or ERR to LEN_LO next cycle, clear done/err, and zero the word index, byte index, and checksum; start SHALL be ignored in the other states.
REQ-016 cpu_hold SHALL be high in LEN_LO, LEN_HI, DATA, CHECK, and ERR, and low in IDLE and DONE.
REQ-017 After LEN_HI is accepted: N > 4096 -> ERR; N = 0 -> CHECK; otherwise -> DATA.
REQ-018 In DATA, bytes SHALL be assembled into a 32-bit word; mem_we SHALL pulse exactly one cycle after the 4th byte's handshake, with mem_addr = word index and mem_wdata = the assembled word.
REQ-019 After each write, the word index SHALL increment; after word N-1 is written, the FSM SHALL go to CHECK.
REQ-020 byte_ready SHALL stay high during the mem_we cycle, allowing back-to-back bytes at one byte per cycle with no stall.
REQ-021 mem_addr SHALL never wrap: N = 4096 writes addresses 0..4095 and then leaves DATA.
REQ-022 Checksum SHALL be the 8-bit XOR of every accepted byte from LEN_LO through the last data byte.
REQ-023 In CHECK, if the accepted byte equals the checksum, the FSM SHALL go to DONE (done = 1); otherwise to ERR (err = 1).
REQ-024 done and err SHALL be level outputs that stay high until the next start or reset, and SHALL never both be high.
REQ-025 mem_we SHALL never assert outside the DATA write cycle.

Reset
REQ-026 On rst_n low, the block SHALL immediately enter IDLE and drive byte_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_hold = 0, done = 0, err = 0, with all counters and the checksum zeroed.
REQ-027 Reset mid-session SHALL abandon the session: no further writes; words already written remain in memory.

Structure
REQ-028 A shared package imem_pkg SHALL hold IMEM_ADDR_W = 12, IMEM_DEPTH = 4096, INSTR_W = 32, and the loader state enum type.
REQ-029 Byte-to-word assembly (byte index, shift register, word-complete flag) SHALL be one sub-module named word_assembler; the FSM, counters, and checksum SHALL stay in imem_loader.

Verification
REQ-030 Stream 02 00 | 13 00 00 00 | 93 00 10 00 | checksum 0x92 SHALL produce writes addr 0 = 0x00000013 and addr 1 = 0x00100093, then done = 1 and cpu_hold = 0.
REQ-031 The same stream with checksum 0x00 SHALL produce both writes, then err = 1, done = 0, and cpu_hold = 1.
REQ-032 Length bytes 01 10 (N = 4097) SHALL produce ERR immediately after LEN_HI, with no mem_we.
REQ-033 Length bytes 00 00 with checksum 00 SHALL produce DONE with no writes.
REQ-034 Continuous byte_valid with random gaps SHALL yield identical writes; N = 4096 SHALL make the last write to addr 0xFFF with no wrap.
REQ-035 rst_n pulled low after 5 data bytes SHALL produce IDLE next edge with all outputs 0 and only addr 0 written; a following start SHALL restart cleanly.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory loader.
// Holds memory geometry, the loader state enum and state decode helpers.
package imem_pkg;

    localparam int IMEM_ADDR_W = 12;
    localparam int IMEM_DEPTH  = 4096;
    localparam int INSTR_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERR
    } ld_state_e;

    function automatic logic takes_byte(ld_state_e s);
        return s inside {LEN_LO, LEN_HI, DATA, CHECK};
    endfunction

    function automatic logic holds_cpu(ld_state_e s);
        return takes_byte(s) || (s == ERR);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream and instruction-memory write port of the loader.
// The host drives the master side, the loader owns the slave side.
interface imem_loader_if;
    import imem_pkg::*;

    logic                   start;
    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   byte_ready;
    logic                   mem_we;
    logic [IMEM_ADDR_W-1:0] mem_addr;
    logic [INSTR_W-1:0]     mem_wdata;
    logic                   cpu_hold;
    logic                   done;
    logic                   err;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, done, err
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, done, err
    );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into instruction words.
// word_done_o pulses the cycle after the fourth byte of a word lands.
module word_assembler
    import imem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [7:0]         byte_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               word_done_o,
    output logic               last_byte_o
);

    logic [1:0]         bidx_q, bidx_d;
    logic [INSTR_W-1:0] sr_q, sr_d;
    logic               done_q, done_d;

    // First byte shifts down to bits 7:0 after four shifts.
    always_comb begin
        bidx_d = bidx_q;
        sr_d   = sr_q;
        done_d = en_i && (bidx_q == 2'd3);
        if (clr_i) begin
            bidx_d = '0;
            sr_d   = '0;
        end else if (en_i) begin
            bidx_d = bidx_q + 2'd1;
            sr_d   = {byte_i, sr_q[INSTR_W-1:8]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bidx_q <= '0;
            sr_q   <= '0;
            done_q <= 1'b0;
        end else begin
            bidx_q <= bidx_d;
            sr_q   <= sr_d;
            done_q <= done_d;
        end
    end

    assign word_o      = sr_q;
    assign word_done_o = done_q;
    assign last_byte_o = (bidx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/words/checksum byte stream into imem writes
// and holds the CPU in reset while a session is running or has failed.
module imem_loader
    import imem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  io
);

    ld_state_e              state_q, state_d;
    logic                   ready_q, hold_q, done_q, err_q;
    logic [IMEM_ADDR_W-1:0] widx_q, widx_d;
    logic [IMEM_ADDR_W-1:0] lenm1_q, lenm1_d;
    logic [7:0]             lenlo_q, lenlo_d;
    logic [7:0]             csum_q, csum_d;
    logic [15:0]            len_w;
    logic                   fire, go, asm_en;
    logic                   we, last_byte, last_word;
    logic [INSTR_W-1:0]     word;

    assign fire      = io.byte_valid && ready_q;
    assign go        = io.start && (state_q inside {IDLE, DONE, ERR});
    assign asm_en    = fire && (state_q == DATA);
    assign len_w     = {io.byte_data, lenlo_q};
    assign last_word = (widx_q == lenm1_q);

    word_assembler u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (go),
        .en_i        (asm_en),
        .byte_i      (io.byte_data),
        .word_o      (word),
        .word_done_o (we),
        .last_byte_o (last_byte)
    );

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        lenm1_d = lenm1_q;
        lenlo_d = lenlo_q;
        csum_d  = csum_q;
        // The final word's write overlaps CHECK; the index stays put.
        if (we && !last_word) widx_d = widx_q + 1'b1;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (go) begin
                    state_d = LEN_LO;
                    widx_d  = '0;
                    csum_d  = '0;
                end
            end
            LEN_LO: begin
                if (fire) begin
                    lenlo_d = io.byte_data;
                    csum_d  = csum_q ^ io.byte_data;
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (fire) begin
                    csum_d  = csum_q ^ io.byte_data;
                    lenm1_d = len_w[IMEM_ADDR_W-1:0] - 1'b1;
                    if (len_w > 16'(IMEM_DEPTH)) state_d = ERR;
                    else if (len_w == '0)        state_d = CHECK;
                    else                         state_d = DATA;
                end
            end
            DATA: begin
                if (fire) begin
                    csum_d = csum_q ^ io.byte_data;
                    if (last_byte && last_word) state_d = CHECK;
                end
            end
            CHECK: begin
                if (fire) state_d = (io.byte_data == csum_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            widx_q  <= '0;
            lenm1_q <= '0;
            lenlo_q <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= takes_byte(state_d);
            hold_q  <= holds_cpu(state_d);
            done_q  <= (state_d == DONE);
            err_q   <= (state_d == ERR);
            widx_q  <= widx_d;
            lenm1_q <= lenm1_d;
            lenlo_q <= lenlo_d;
            csum_q  <= csum_d;
        end
    end

    assign io.byte_ready = ready_q;
    assign io.mem_we     = we;
    assign io.mem_addr   = widx_q;
    assign io.mem_wdata  = word;
    assign io.cpu_hold   = hold_q;
    assign io.done       = done_q;
    assign io.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the
// stimulus and popped by a monitor whenever mem_we is seen.
module tb_imem_loader;
    import imem_pkg::*;

    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] a;
        logic [INSTR_W-1:0]     d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    wr_t                    exp_q[$];
    int                     vecs = 0;
    int                     bad  = 0;
    int                     gapmax = 0;
    logic [7:0]             cs;
    logic [IMEM_ADDR_W-1:0] last_a = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done && bus.err) begin
            vecs++;
            bad++;
            $display("FAIL done_err_both: got 11, want not both");
        end
        if (bus.mem_we) begin
            if (exp_q.size() == 0) begin
                vecs++;
                bad++;
                $display("FAIL stray_write: got addr %h data %h, want none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write", {bus.mem_addr, bus.mem_wdata}, {e.a, e.d});
                last_a = bus.mem_addr;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        repeat ($urandom_range(0, gapmax)) begin
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.byte_ready) begin
            vecs++;
            bad++;
            $display("FAIL ready_timeout: got 0, want 1");
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        cs = cs ^ b;
        send_byte(b);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cs = 8'h00;
    endtask

    // Two-word program: 0x00000013 then 0x00100093, good checksum 0x92.
    task automatic basic(input logic [7:0] ck);
        logic [7:0] s [10];
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00};
        do_start();
        exp_q.push_back('{a: 12'h000, d: 32'h0000_0013});
        exp_q.push_back('{a: 12'h001, d: 32'h0010_0093});
        for (int i = 0; i < 10; i++) feed(s[i]);
        send_byte(ck);
    endtask

    task automatic status(input string nm, input logic d,
                          input logic e, input logic h);
        chk(nm, {bus.done, bus.err, bus.cpu_hold}, {d, e, h});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        rst_n          = 1'b0;
        #12;
        chk("rst_outs", {bus.byte_ready, bus.mem_we, bus.cpu_hold,
                         bus.done, bus.err}, 5'b0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        status("idle_status", 0, 0, 0);

        do_start();
        chk("start_ready", {bus.byte_ready, bus.cpu_hold}, 2'b11);
        basic(8'h92);
        status("good_sum", 1, 0, 0);
        chk("good_sum_ready", bus.byte_ready, 0);
        chk("good_sum_drain", exp_q.size(), 0);

        // Bytes offered while DONE must be ignored.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        status("ignored_bytes", 1, 0, 0);

        basic(8'h00);
        status("bad_sum", 0, 1, 1);
        chk("bad_sum_drain", exp_q.size(), 0);

        do_start();
        feed(8'h01);
        feed(8'h10);
        status("len_4097", 0, 1, 1);
        chk("len_4097_ready", bus.byte_ready, 0);

        do_start();
        feed(8'h00);
        feed(8'h00);
        send_byte(8'h00);
        status("len_zero", 1, 0, 0);

        gapmax = 3;
        basic(8'h92);
        gapmax = 0;
        status("gappy", 1, 0, 0);
        chk("gappy_drain", exp_q.size(), 0);

        do_start();
        feed(8'h00);
        feed(8'h10);
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            w = (i * 32'h9E37_79B1) ^ 32'h0000_0013;
            exp_q.push_back('{a: i[IMEM_ADDR_W-1:0], d: w});
            feed(w[7:0]);
            feed(w[15:8]);
            feed(w[23:16]);
            feed(w[31:24]);
        end
        send_byte(cs);
        status("full_4096", 1, 0, 0);
        chk("full_last_addr", last_a, 12'hFFF);
        chk("full_drain", exp_q.size(), 0);

        do_start();
        exp_q.push_back('{a: 12'h000, d: 32'h0000_0013});
        feed(8'h02);
        feed(8'h00);
        feed(8'h13);
        feed(8'h00);
        feed(8'h00);
        feed(8'h00);
        feed(8'h93);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {bus.byte_ready, bus.mem_we, bus.cpu_hold,
                            bus.done, bus.err, bus.mem_addr,
                            bus.mem_wdata}, 0);
        @(posedge clk); #1;
        chk("midrst_edge", {bus.byte_ready, bus.mem_we, bus.cpu_hold,
                            bus.done, bus.err, bus.mem_addr,
                            bus.mem_wdata}, 0);
        chk("midrst_drain", exp_q.size(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        basic(8'h92);
        status("restart", 1, 0, 0);
        chk("restart_drain", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
